pipeline_execute_stage: RTL and testbench

//  Parametrised execute stage of the pipelined CPU, between decode/regread and memory.

---
 rtl/pipeline_execute_stage.sv | 216 +++++++++++++++++++++
 tb/tb_pipeline_execute_stage.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_execute_stage
// Purpose  : Execute stage between decode/regread and memory. It captures the
//            operands under a valid/ready handshake, shifts Rm, and computes
//            the ALU result or an iterative shift-add multiply. It also
//            maintains the architectural {N,Z,V} flags. Back-pressure from
//            downstream stalls the stage without losing the held instruction.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                    in   clock, rising edge
//   rst                    in   asynchronous reset, active-low
//   in_valid / in_ready    upstream handshake (in_ready independent of in_valid)
//   control_in             in   control word
//   data_Rm_in/Rn_in/Rd_in in   register operands
//   imm_in                 in   immediate
//   inst_type_in           in   instruction class, passed through
//   out_valid / out_ready  downstream handshake
//   control_out            out  registered control word
//   data_Rd_out            out  registered Rd (store data)
//   result_out             out  ALU / multiply result
//   inst_type_out          out  registered instruction class
//   loads                  out  control_out[8]
//   highbit_shifted_Rm_out out  MSB of shifted Rm
//   highbit_data_Rn_out    out  MSB of registered Rn
//   status_out             out  {N,Z,V} architectural flags
//   busy                   out  multiply in progress
// ============================================================================
module pipeline_execute_stage #(
  parameter int WIDTH   = 16,
  parameter int CTRL_W  = 22,
  parameter int ITYPE_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  control_in,
  input  logic [WIDTH-1:0]   data_Rm_in,
  input  logic [WIDTH-1:0]   data_Rn_in,
  input  logic [WIDTH-1:0]   data_Rd_in,
  input  logic [WIDTH-1:0]   imm_in,
  input  logic [ITYPE_W-1:0] inst_type_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  control_out,
  output logic [WIDTH-1:0]   data_Rd_out,
  output logic [WIDTH-1:0]   result_out,
  output logic [ITYPE_W-1:0] inst_type_out,
  output logic               loads,
  output logic               highbit_shifted_Rm_out,
  output logic               highbit_data_Rn_out,
  output logic [2:0]         status_out,
  output logic               busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_MUL   = 2'b01,
    S_FULL  = 2'b10
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CTRL_W-1:0]  ctrl_q;
  logic [WIDTH-1:0]   rm_q;
  logic [WIDTH-1:0]   rn_q;
  logic [WIDTH-1:0]   rd_q;
  logic [WIDTH-1:0]   imm_q;
  logic [ITYPE_W-1:0] itype_q;
  logic [WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         status_q;

  // Decode of the registered control word
  logic       asel;
  logic       bsel;
  logic       is_mul;
  logic       setflags;
  logic [1:0] alu_op;
  logic [1:0] shift_op;

  assign asel     = ctrl_q[10];
  assign bsel     = ctrl_q[9];
  assign alu_op   = ctrl_q[7:6];
  assign shift_op = ctrl_q[5:4];
  assign is_mul   = ctrl_q[11];
  assign setflags = ctrl_q[12];

  logic [WIDTH-1:0] shifted_rm;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic [WIDTH-1:0] result;
  logic [2:0]       flags;
  logic [WIDTH-1:0] partial;
  logic             accept;
  logic             out_fire;

  always_comb begin
    shifted_rm = rm_q;
    case (shift_op)
      2'b01:   shifted_rm = {rm_q[WIDTH-2:0], 1'b0};
      2'b10:   shifted_rm = {1'b0, rm_q[WIDTH-1:1]};
      2'b11:   shifted_rm = {rm_q[WIDTH-1], rm_q[WIDTH-1:1]};
      default: shifted_rm = rm_q;
    endcase
  end

  assign op_a    = bsel ? imm_q : rn_q;
  assign op_b    = asel ? '0 : shifted_rm;
  assign add_res = op_a + op_b;
  assign sub_res = op_a - op_b;

  // Signed overflow: operands agree (ADD) or differ (SUB) in sign while
  // the result's sign departs from A.
  always_comb begin
    alu_res = add_res;
    alu_v   = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_res = add_res;
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      2'b01: begin
        alu_res = sub_res;
        alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      2'b10:   alu_res = op_a & op_b;
      default: alu_res = ~op_b;
    endcase
  end

  // The accumulator holds the finished product once the FSM leaves S_MUL.
  assign result = is_mul ? acc_q : alu_res;
  assign flags  = {result[WIDTH-1], (result == '0), (is_mul ? 1'b0 : alu_v)};

  // One multiplier bit per cycle; operands stay stable in their registers.
  assign partial = op_b[cnt_q] ? (op_a << cnt_q) : '0;

  assign in_ready  = (state_q == S_EMPTY) || ((state_q == S_FULL) && out_ready);
  assign out_valid = (state_q == S_FULL);
  assign busy      = (state_q == S_MUL);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (in_valid) state_d = control_in[11] ? S_MUL : S_FULL;
      end
      S_MUL: begin
        if (cnt_q == CNT_LAST) state_d = S_FULL;
      end
      S_FULL: begin
        if (out_ready) begin
          if (in_valid) state_d = control_in[11] ? S_MUL : S_FULL;
          else          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_EMPTY;
      ctrl_q   <= '0;
      rm_q     <= '0;
      rn_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      itype_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctrl_q  <= control_in;
        rm_q    <= data_Rm_in;
        rn_q    <= data_Rn_in;
        rd_q    <= data_Rd_in;
        imm_q   <= imm_in;
        itype_q <= inst_type_in;
        acc_q   <= '0;
        cnt_q   <= '0;
      end else if (state_q == S_MUL) begin
        acc_q <= acc_q + partial;
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      // Flags belong to the instruction leaving the stage on this edge.
      if (out_fire && setflags) status_q <= flags;
    end
  end

  assign control_out            = ctrl_q;
  assign data_Rd_out            = rd_q;
  assign result_out             = result;
  assign inst_type_out          = itype_q;
  assign loads                  = ctrl_q[8];
  assign highbit_shifted_Rm_out = shifted_rm[WIDTH-1];
  assign highbit_data_Rn_out    = rn_q[WIDTH-1];
  assign status_out             = status_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_execute_stage
// Purpose  : Self-checking bench for pipeline_execute_stage. Directed cases
//            plus randomized traffic compared against a timing/arithmetic
//            reference model held in a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_execute_stage;

  localparam int W  = 16;
  localparam int CW = 22;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] control_in;
  logic [W-1:0]  data_Rm_in;
  logic [W-1:0]  data_Rn_in;
  logic [W-1:0]  data_Rd_in;
  logic [W-1:0]  imm_in;
  logic [IW-1:0] inst_type_in;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] control_out;
  logic [W-1:0]  data_Rd_out;
  logic [W-1:0]  result_out;
  logic [IW-1:0] inst_type_out;
  logic          loads;
  logic          highbit_shifted_Rm_out;
  logic          highbit_data_Rn_out;
  logic [2:0]    status_out;
  logic          busy;

  always #5 clk = ~clk;

  pipeline_execute_stage #(.WIDTH(W), .CTRL_W(CW), .ITYPE_W(IW)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .control_in             (control_in),
    .data_Rm_in             (data_Rm_in),
    .data_Rn_in             (data_Rn_in),
    .data_Rd_in             (data_Rd_in),
    .imm_in                 (imm_in),
    .inst_type_in           (inst_type_in),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .control_out            (control_out),
    .data_Rd_out            (data_Rd_out),
    .result_out             (result_out),
    .inst_type_out          (inst_type_out),
    .loads                  (loads),
    .highbit_shifted_Rm_out (highbit_shifted_Rm_out),
    .highbit_data_Rn_out    (highbit_data_Rn_out),
    .status_out             (status_out),
    .busy                   (busy)
  );

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [W-1:0]  rd;
    logic [W-1:0]  rn;
    logic [W-1:0]  res;
    logic [IW-1:0] itype;
    logic          hb_rm;
    logic [2:0]    flags;
    int            ready_cyc;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  bit         last_accept = 1'b0;
  bit         rand_or = 1'b0;
  logic [2:0] exp_status = 3'b000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] mk_ctrl(input bit mul, input bit setf, input bit asel,
                                            input bit bsel, input bit ld,
                                            input logic [1:0] op, input logic [1:0] sh);
    logic [CW-1:0] c;
    c      = '0;
    c[12]  = setf;
    c[11]  = mul;
    c[10]  = asel;
    c[9]   = bsel;
    c[8]   = ld;
    c[7:6] = op;
    c[5:4] = sh;
    return c;
  endfunction

  // Arithmetic reference: values from the instruction's meaning, not its gates.
  function automatic exp_t model(input logic [CW-1:0] c, input logic [W-1:0] rn,
                                 input logic [W-1:0] rm, input logic [W-1:0] rd,
                                 input logic [W-1:0] imm, input logic [IW-1:0] it);
    exp_t        e;
    logic [W-1:0] sh, a, b, r;
    int          s, sa, sb;
    longint      p;
    bit          v;
    case (c[5:4])
      2'b00:   sh = rm;
      2'b01:   sh = W'(int'(rm) * 2);
      2'b10:   sh = W'(int'(rm) / 2);
      default: sh = W'($signed(rm) >>> 1);
    endcase
    a  = c[9] ? imm : rn;
    b  = c[10] ? '0 : sh;
    sa = int'($signed(a));
    sb = int'($signed(b));
    v  = 1'b0;
    if (c[11]) begin
      p = longint'(a) * longint'(b);
      r = p[W-1:0];
    end else begin
      case (c[7:6])
        2'b00: begin s = sa + sb; r = W'(s); v = (s > (2**(W-1)) - 1) || (s < -(2**(W-1))); end
        2'b01: begin s = sa - sb; r = W'(s); v = (s > (2**(W-1)) - 1) || (s < -(2**(W-1))); end
        2'b10: r = a & b;
        default: r = ~b;
      endcase
    end
    e.ctrl      = c;
    e.rd        = rd;
    e.rn        = rn;
    e.res       = r;
    e.itype     = it;
    e.hb_rm     = sh[W-1];
    e.flags     = {r[W-1], (r == '0), v};
    e.ready_cyc = 0;
    return e;
  endfunction

  // Occupancy model: one instruction in flight, visible from ready_cyc on.
  always @(negedge clk) begin
    bit   m_valid, m_busy, m_ready;
    exp_t e;
    if (!rst) begin
      q.delete();
      exp_status  = 3'b000;
      last_accept = 1'b0;
    end else begin
      m_valid = (q.size() > 0) && (cyc >= q[0].ready_cyc);
      m_busy  = (q.size() > 0) && !m_valid;
      m_ready = (q.size() == 0) || (m_valid && out_ready);
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("busy", 32'(busy), 32'(m_busy));
      check("in_ready", 32'(in_ready), 32'(m_ready));
      check("status", 32'(status_out), 32'(exp_status));
      if (m_valid) begin
        check("result", 32'(result_out), 32'(q[0].res));
        check("control", 32'(control_out), 32'(q[0].ctrl));
        check("rd", 32'(data_Rd_out), 32'(q[0].rd));
        check("itype", 32'(inst_type_out), 32'(q[0].itype));
        check("loads", 32'(loads), 32'(q[0].ctrl[8]));
        check("hb_rm", 32'(highbit_shifted_Rm_out), 32'(q[0].hb_rm));
        check("hb_rn", 32'(highbit_data_Rn_out), 32'(q[0].rn[W-1]));
        if (out_ready) begin
          if (q[0].ctrl[12]) exp_status = q[0].flags;
          void'(q.pop_front());
        end
      end
      last_accept = in_valid && m_ready;
      if (last_accept) begin
        e = model(control_in, data_Rn_in, data_Rm_in, data_Rd_in, imm_in, inst_type_in);
        e.ready_cyc = cyc + 1 + (control_in[11] ? W : 0);
        q.push_back(e);
      end
    end
    cyc++;
  end

  always @(posedge clk) begin
    if (rand_or) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [CW-1:0] c, input logic [W-1:0] rn, input logic [W-1:0] rm,
                      input logic [W-1:0] rd, input logic [W-1:0] imm, input logic [IW-1:0] it,
                      output int waited);
    in_valid     = 1'b1;
    control_in   = c;
    data_Rn_in   = rn;
    data_Rm_in   = rm;
    data_Rd_in   = rd;
    imm_in       = imm;
    inst_type_in = it;
    waited       = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!last_accept && waited < 200);
    if (!last_accept) check("accept_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(out_valid), 32'(1));
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            w;
    logic [CW-1:0] c;
    rst          = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    control_in   = '0;
    data_Rm_in   = '0;
    data_Rn_in   = '0;
    data_Rd_in   = '0;
    imm_in       = '0;
    inst_type_in = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_control", 32'(control_out), 32'(0));
    check("rst_status", 32'(status_out), 32'(0));
    check("rst_result", 32'(result_out), 32'(0));
    check("rst_itype", 32'(inst_type_out), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ADD overflow into the sign bit
    send(mk_ctrl(0, 1, 0, 0, 0, 2'b00, 2'b00), 16'h7FFF, 16'h0001, 16'h1234, 16'h0, 6'h05, w);
    check("add_lat", 32'(w), 32'(1));
    check("add_res", 32'(result_out), 32'h8000);
    @(posedge clk); #1;
    check("add_status", 32'(status_out), 32'(3'b101));

    // SUB with ASR'd Rm -> zero
    send(mk_ctrl(0, 1, 0, 0, 0, 2'b01, 2'b11), 16'h0005, 16'h000A, 16'h0, 16'h0, 6'h01, w);
    check("sub_res", 32'(result_out), 32'h0000);
    @(posedge clk); #1;
    check("sub_status", 32'(status_out), 32'(3'b010));

    // NOT with B forced to zero; no setflags so status holds
    send(mk_ctrl(0, 0, 1, 0, 1, 2'b11, 2'b01), 16'h1111, 16'h2222, 16'h0, 16'h0, 6'h02, w);
    check("not_res", 32'(result_out), 32'hFFFF);
    check("not_loads", 32'(loads), 32'(1));
    @(posedge clk); #1;
    check("not_status", 32'(status_out), 32'(3'b010));

    // MUL 3*5: busy for W cycles with in_ready low
    send(mk_ctrl(1, 1, 0, 0, 0, 2'b00, 2'b00), 16'h0003, 16'h0005, 16'h0, 16'h0, 6'h03, w);
    for (int i = 0; i < W; i++) begin
      check("mul_busy", 32'(busy), 32'(1));
      check("mul_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk); #1;
    end
    check("mul_valid", 32'(out_valid), 32'(1));
    check("mul_res", 32'(result_out), 32'h000F);
    @(posedge clk); #1;
    check("mul_status", 32'(status_out), 32'(3'b000));

    // MUL wrap via immediate operand
    send(mk_ctrl(1, 0, 0, 1, 0, 2'b10, 2'b00), 16'h0, 16'h0100, 16'h0, 16'h0100, 6'h04, w);
    wait_out("mulw_valid");
    check("mulw_res", 32'(result_out), 32'h0000);
    @(posedge clk); #1;

    // Back-pressure: hold for 5 cycles, then zero-bubble handover
    out_ready = 1'b0;
    send(mk_ctrl(0, 0, 0, 0, 0, 2'b00, 2'b00), 16'h0001, 16'h0002, 16'hABCD, 16'h0, 6'h06, w);
    repeat (5) begin
      check("bp_valid", 32'(out_valid), 32'(1));
      check("bp_res", 32'(result_out), 32'h0003);
      check("bp_rd", 32'(data_Rd_out), 32'hABCD);
      check("bp_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk); #1;
    end
    in_valid     = 1'b1;
    control_in   = mk_ctrl(0, 1, 0, 0, 0, 2'b01, 2'b00);
    data_Rn_in   = 16'h0001;
    data_Rm_in   = 16'h0002;
    data_Rd_in   = 16'h0;
    inst_type_in = 6'h07;
    out_ready    = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", 32'(out_valid), 32'(1));
    check("bp_next_res", 32'(result_out), 32'hFFFF);
    @(posedge clk); #1;
    check("bp_next_status", 32'(status_out), 32'(3'b100));

    // Reset in the middle of a multiply
    send(mk_ctrl(1, 1, 0, 0, 0, 2'b00, 2'b00), 16'h0007, 16'h0009, 16'h0, 16'h0, 6'h08, w);
    repeat (3) @(posedge clk);
    #1;
    check("midmul_busy", 32'(busy), 32'(1));
    rst = 1'b0;
    #1;
    check("mulrst_valid", 32'(out_valid), 32'(0));
    check("mulrst_busy", 32'(busy), 32'(0));
    check("mulrst_status", 32'(status_out), 32'(0));
    check("mulrst_control", 32'(control_out), 32'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send(mk_ctrl(0, 0, 0, 0, 0, 2'b00, 2'b00), 16'h0002, 16'h0002, 16'h0, 16'h0, 6'h09, w);
    check("post_rst_lat", 32'(w), 32'(1));
    check("post_rst_res", 32'(result_out), 32'h0004);
    @(posedge clk); #1;

    // Streaming: one result per cycle, in order
    for (int i = 0; i < 8; i++) begin
      send(mk_ctrl(0, 0, 0, 0, 0, 2'b00, 2'b00), W'(3 * i + 1), W'(i), W'(i), 16'h0, IW'(i), w);
      check("stream_lat", 32'(w), 32'(1));
      check("stream_res", 32'(result_out), 32'(4 * i + 1));
    end
    @(posedge clk); #1;

    // Randomized traffic with random back-pressure
    rand_or = 1'b1;
    repeat (250) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      c     = CW'($urandom);
      c[11] = ($urandom_range(0, 3) == 0);
      send(c, rand_opnd(), rand_opnd(), W'($urandom), rand_opnd(), IW'($urandom), w);
    end
    rand_or = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("drain", 32'(q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
